golomb_run_encoder: RTL and testbench

GOLOMB_RUN_ENCODER -- requirements
Module: golomb_run_encoder

---
 rtl/golomb_run_encoder.sv | 212 +++++++++++++++++++++
 tb/tb_golomb_run_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/golomb_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : golomb_run_encoder
// Description : Zero-run-length Golomb encoder. Counts 0 bits of the input
//               stream; a 1 bit (or a flush) ends the run, which is emitted
//               serially as q ones, a 0 separator and a k-bit remainder,
//               with q = run / m and r = run % m. A run that reaches the
//               counter maximum is emitted without a terminating 1.
//               Optional statistics counters are built when the macro
//               GOLOMB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module golomb_run_encoder #(
   parameter int RUN_W = 8,
   parameter int M_W   = 8,
   parameter int K_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [M_W-1:0]   cfg_m,
   input  logic [K_W-1:0]   cfg_k,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy
`ifdef GOLOMB_STATS_EN
   ,
   output logic [31:0]      stat_cw,
   output logic [31:0]      stat_bits
`endif
);

   // Comparison width wide enough for both the residue and the divisor.
   localparam int C_CW = ((RUN_W > M_W) ? RUN_W : M_W) + 1;
   localparam logic [RUN_W-1:0] C_RUN_MAX = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0] C_RUN_SAT = C_RUN_MAX - RUN_W'(1);

   typedef enum logic [1:0] {
      ST_COUNT = 2'd0,
      ST_UNARY = 2'd1,
      ST_SEP   = 2'd2,
      ST_REM   = 2'd3
   } state_t;

   state_t             r_state;
   logic [RUN_W-1:0]   r_run;
   logic [RUN_W-1:0]   r_res;
   logic [M_W-1:0]     r_m;
   logic [K_W-1:0]     r_k;
   logic [K_W-1:0]     r_cnt;

   state_t             w_state_nxt;
   logic [RUN_W-1:0]   w_run_nxt;
   logic [RUN_W-1:0]   w_res_nxt;
   logic [M_W-1:0]     w_m_nxt;
   logic [K_W-1:0]     w_k_nxt;
   logic [K_W-1:0]     w_cnt_nxt;

   logic               w_out_xfer;
   logic               w_sat;
   logic               w_latch;
   logic [RUN_W-1:0]   w_lat_run;
   logic [M_W-1:0]     w_cfg_m_eff;
   logic               w_lat_ge;
   logic [C_CW-1:0]    w_res_sub_ext;
   logic               w_sub_ge;
   logic [K_W-1:0]     w_idx;
   logic [RUN_W-1:0]   w_rem_mask;

   assign w_out_xfer  = out_valid && out_ready;

   // A divisor of zero behaves as one.
   assign w_cfg_m_eff = (cfg_m == '0) ? M_W'(1) : cfg_m;

   // A 0 arriving one short of the counter maximum closes the run at the
   // maximum value; the decoder reads such a codeword as a continuation.
   assign w_sat       = in_valid && !in_bit && (r_run == C_RUN_SAT);

   // Codeword start: terminating 1, saturating 0, or a flush of a non-empty
   // run when no bit is presented in the same cycle.
   assign w_latch     = (r_state == ST_COUNT) &&
                        ((in_valid && (in_bit || w_sat)) ||
                         (!in_valid && flush && (r_run != '0)));
   assign w_lat_run   = w_sat ? C_RUN_MAX : r_run;

   // Decide at latch time whether any unary ones are due, so that a quotient
   // of zero goes straight to the separator without an idle cycle.
   assign w_lat_ge    = C_CW'(w_lat_run) >= C_CW'(w_cfg_m_eff);

   // Residue after emitting one more unary 1, and whether another follows.
   assign w_res_sub_ext = C_CW'(r_res) - C_CW'(r_m);
   assign w_sub_ge      = w_res_sub_ext >= C_CW'(r_m);

   // Remainder bit select; positions at or above RUN_W read as zero.
   assign w_idx      = r_cnt - K_W'(1);
   assign w_rem_mask = RUN_W'(1) << w_idx;

   // State and working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_COUNT;
         r_run   <= '0;
         r_res   <= '0;
         r_m     <= '0;
         r_k     <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_res   <= w_res_nxt;
         r_m     <= w_m_nxt;
         r_k     <= w_k_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_res_nxt   = r_res;
      w_m_nxt     = r_m;
      w_k_nxt     = r_k;
      w_cnt_nxt   = r_cnt;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_bit     = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b0;

      case (r_state)
         ST_COUNT: begin
            in_ready = 1'b1;
            if (w_latch) begin
               // Snapshot run and configuration; later cfg changes are
               // ignored until this codeword completes.
               w_res_nxt   = w_lat_run;
               w_m_nxt     = w_cfg_m_eff;
               w_k_nxt     = cfg_k;
               w_run_nxt   = '0;
               w_state_nxt = w_lat_ge ? ST_UNARY : ST_SEP;
            end else if (in_valid && !in_bit) begin
               w_run_nxt = r_run + RUN_W'(1);
            end
         end

         ST_UNARY: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_bit   = 1'b1;
            if (w_out_xfer) begin
               w_res_nxt   = w_res_sub_ext[RUN_W-1:0];
               w_state_nxt = w_sub_ge ? ST_UNARY : ST_SEP;
            end
         end

         ST_SEP: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_bit   = 1'b0;
            out_last  = (r_k == '0);
            if (w_out_xfer) begin
               if (r_k == '0) begin
                  w_state_nxt = ST_COUNT;
               end else begin
                  w_cnt_nxt   = r_k;
                  w_state_nxt = ST_REM;
               end
            end
         end

         ST_REM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_bit   = |(r_res & w_rem_mask);
            out_last  = (r_cnt == K_W'(1));
            if (w_out_xfer) begin
               w_cnt_nxt = r_cnt - K_W'(1);
               if (r_cnt == K_W'(1)) begin
                  w_state_nxt = ST_COUNT;
               end
            end
         end

         default: begin
            w_state_nxt = ST_COUNT;
         end
      endcase
   end

`ifdef GOLOMB_STATS_EN
   // Free-running, wrapping counts of completed codewords and emitted bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cw   <= '0;
         stat_bits <= '0;
      end else if (w_out_xfer) begin
         stat_bits <= stat_bits + 32'd1;
         if (out_last) begin
            stat_cw <= stat_cw + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_golomb_run_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_golomb_run_encoder
// Description : Directed, table-driven bench for golomb_run_encoder with
//               RUN_W=4 so that run saturation is reachable; hand sequences
//               cover saturation, flush corners, back-pressure and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_golomb_run_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_m = 8'd4;
   logic [3:0]  cfg_k = 4'd2;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_bit;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        busy;
`ifdef GOLOMB_STATS_EN
   logic [31:0] stat_cw;
   logic [31:0] stat_bits;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int viol  = 0;

   golomb_run_encoder #(.RUN_W(4), .M_W(8), .K_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_m     (cfg_m),
      .cfg_k     (cfg_k),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef GOLOMB_STATS_EN
      ,
      .stat_cw   (stat_cw),
      .stat_bits (stat_bits)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  m;
      logic [3:0]  k;
      int          run;
      bit          use_flush;
      int          len;
      logic [31:0] bits;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered and left on a negedge; the bit is held across one posedge.
   task automatic send_bit(input logic b);
      if (!in_ready) viol++;
      in_valid = 1'b1;
      in_bit   = b;
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   // Collect one codeword; optionally toggle out_ready and hold flush high.
   task automatic collect(input bit toggle, input bit flush_hold,
                          output logic [31:0] cap, output int n);
      bit   done = 0;
      int   cycles = 0;
      logic prev_v = 0, prev_r = 1, prev_b = 0, prev_l = 0;
      cap = '0;
      n   = 0;
      while (!done && cycles < 100) begin
         out_ready = toggle ? (cycles % 2 == 0) : 1'b1;
         flush     = flush_hold;
         if (out_valid && (in_ready || !busy)) viol++;
         if (prev_v && !prev_r &&
             (!out_valid || out_bit !== prev_b || out_last !== prev_l)) viol++;
         if (out_valid && out_ready) begin
            cap = {cap[30:0], out_bit};
            n++;
            if (out_last) done = 1;
         end
         prev_v = out_valid; prev_r = out_ready;
         prev_b = out_bit;   prev_l = out_last;
         @(negedge clk);
         cycles++;
      end
      flush     = 1'b0;
      out_ready = 1'b1;
      chk("collect_completed", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cap;
      int          n;
      int          seen;

      //            m      k     run flush len bits
      vt[0]  = '{8'd4,  4'd2,  5,  0,  4, 32'b1001};
      vt[1]  = '{8'd4,  4'd2,  0,  0,  3, 32'b000};
      vt[2]  = '{8'd3,  4'd2,  7,  0,  5, 32'b11001};
      vt[3]  = '{8'd1,  4'd0,  2,  1,  3, 32'b110};
      vt[4]  = '{8'd0,  4'd0,  3,  0,  4, 32'b1110};
      vt[5]  = '{8'd8,  4'd3, 13,  0,  5, 32'b10101};
      vt[6]  = '{8'd5,  4'd3,  4,  0,  4, 32'b0100};
      vt[7]  = '{8'd2,  4'd1,  6,  1,  5, 32'b11100};
      vt[8]  = '{8'd16, 4'd4, 14,  0,  5, 32'b01110};
      vt[9]  = '{8'd4,  4'd0,  9,  0,  3, 32'b110};
      vt[10] = '{8'd2,  4'd8,  3,  0, 10, 32'b1000000001};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {28'd0, out_valid, out_bit, out_last, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_idle", {30'd0, out_valid, busy}, 32'd0);

      // Table-driven codewords.
      for (int i = 0; i < 11; i++) begin
         cfg_m = vt[i].m;
         cfg_k = vt[i].k;
         for (int z = 0; z < vt[i].run; z++) send_bit(1'b0);
         if (vt[i].use_flush) do_flush();
         else                 send_bit(1'b1);
         chk($sformatf("v%0d_first_valid", i), {31'd0, out_valid}, 32'd1);
         collect(0, 0, cap, n);
         chk($sformatf("v%0d_len", i), n, vt[i].len);
         chk($sformatf("v%0d_bits", i), cap, vt[i].bits);
      end

      // Saturation: 15 zeros with RUN_W=4 produce a codeword on their own.
      cfg_m = 8'd4; cfg_k = 4'd2;
      repeat (14) send_bit(1'b0);
      chk("sat_pre_idle", {31'd0, out_valid}, 32'd0);
      send_bit(1'b0);
      chk("sat_started", {31'd0, out_valid}, 32'd1);
      collect(0, 0, cap, n);
      chk("sat_len", n, 6);
      chk("sat_bits", cap, 32'b111011);
      send_bit(1'b0);
      chk("sat_next_idle", {31'd0, out_valid}, 32'd0);
      send_bit(1'b1);
      collect(0, 0, cap, n);
      chk("sat_next_len", n, 3);
      chk("sat_next_bits", cap, 32'b001);

      // Flush alongside an accepted 0: bit extends the run, flush ignored.
      send_bit(1'b0); send_bit(1'b0);
      flush = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_with_bit_idle", {30'd0, out_valid, busy}, 32'd0);
      send_bit(1'b1);
      collect(0, 0, cap, n);
      chk("flush_with_bit_len", n, 3);
      chk("flush_with_bit_bits", cap, 32'b011);

      // Flush with an empty run produces nothing.
      do_flush();
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (out_valid || busy) seen++;
         @(negedge clk);
      end
      chk("flush_empty_no_output", seen, 0);

      // Back-pressure, cfg change and flush during emission.
      viol = 0;
      cfg_m = 8'd4; cfg_k = 4'd2;
      repeat (5) send_bit(1'b0);
      send_bit(1'b1);
      cfg_m = 8'd1; cfg_k = 4'd0;
      collect(1, 1, cap, n);
      chk("stall_len", n, 4);
      chk("stall_bits", cap, 32'b1001);
      chk("stall_protocol_violations", viol, 0);
      chk("stall_after_ready", {30'd0, in_ready, out_valid}, 32'b10);

      // Reset in the middle of a long unary field.
      cfg_m = 8'd1; cfg_k = 4'd0;
      repeat (9) send_bit(1'b0);
      send_bit(1'b1);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_reset_unary", {30'd0, out_valid, out_bit}, 32'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", {28'd0, out_valid, out_bit, out_last, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", {30'd0, in_ready, out_valid}, 32'b10);
      cfg_m = 8'd4; cfg_k = 4'd2;
      send_bit(1'b1);
      collect(0, 0, cap, n);
      chk("post_reset_len", n, 3);
      chk("post_reset_bits", cap, 32'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
